// File: rtl/dct_collector.sv
// rtl/dct_collector.sv - gathers the first N_COEFF beats of each DCT frame into a vector.
// Optional macro DCT_COLLECT_SKIP_C0_EN drops beat 0 (DC term) and collects beats 1..N_COEFF.
module dct_collector #(
  parameter int N_FRAME = 128,
  parameter int N_COEFF = 13
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic signed [15:0] dct_data_in,
  input  logic               dct_valid_in,
  input  logic               dct_last_in,
  output logic               dct_ready_out,
  output logic signed [15:0] mfcc_data_out [N_COEFF],
  output logic               mfcc_valid_out,
  input  logic               mfcc_ready_in,
  output logic               frame_err_out
);

`ifdef DCT_COLLECT_SKIP_C0_EN
  localparam int SKIP = 1;
`else
  localparam int SKIP = 0;
`endif

  localparam int            CW         = $clog2(N_FRAME + 1);
  localparam logic [CW-1:0] K_MIN_LAST = CW'(N_COEFF - 1 + SKIP);
  localparam logic [CW-1:0] K_MAX      = CW'(N_FRAME - 1);

  typedef enum logic [1:0] {
    COLLECT,
    DRAIN,
    HOLD
  } state_t;

  state_t        state;
  logic [CW-1:0] k;
  logic          accept;

  assign accept = dct_valid_in & dct_ready_out;

  // dct_ready_out is registered from the next state, so it never depends on inputs combinationally.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state          <= COLLECT;
      k              <= '0;
      dct_ready_out  <= 1'b0;
      mfcc_valid_out <= 1'b0;
      frame_err_out  <= 1'b0;
      for (int i = 0; i < N_COEFF; i++) begin
        mfcc_data_out[i] <= '0;
      end
    end else begin
      frame_err_out <= 1'b0;
      dct_ready_out <= 1'b1;
      case (state)
        COLLECT: begin
          if (accept) begin
            for (int i = 0; i < N_COEFF; i++) begin
              if (k == CW'(i + SKIP)) begin
                mfcc_data_out[i] <= dct_data_in;
              end
            end
            if (dct_last_in) begin
              k <= '0;
              if (k >= K_MIN_LAST) begin
                state          <= HOLD;
                mfcc_valid_out <= 1'b1;
                dct_ready_out  <= 1'b0;
              end else begin
                frame_err_out <= 1'b1;
              end
            end else if (k == K_MAX) begin
              // Frame ran past N_FRAME beats without last: flush the rest of it.
              k             <= '0;
              frame_err_out <= 1'b1;
              state         <= DRAIN;
            end else begin
              k <= k + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (accept && dct_last_in) begin
            state <= COLLECT;
          end
        end
        HOLD: begin
          if (mfcc_ready_in) begin
            state          <= COLLECT;
            mfcc_valid_out <= 1'b0;
          end else begin
            dct_ready_out <= 1'b0;
          end
        end
        default: begin
          state          <= COLLECT;
          k              <= '0;
          mfcc_valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dct_collector.sv
// tb/tb_dct_collector.sv - directed table-driven bench for dct_collector.
module tb_dct_collector;

  localparam int N_FRAME = 128;
  localparam int N_COEFF = 13;
`ifdef DCT_COLLECT_SKIP_C0_EN
  localparam int SKIP = 1;
`else
  localparam int SKIP = 0;
`endif
  localparam int MIN_LAST = N_COEFF - 1 + SKIP;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic signed [15:0] dct_data_in;
  logic               dct_valid_in;
  logic               dct_last_in;
  logic               dct_ready_out;
  logic signed [15:0] mfcc_data_out [N_COEFF];
  logic               mfcc_valid_out;
  logic               mfcc_ready_in;
  logic               frame_err_out;

  int n_checks = 0;
  int n_fail   = 0;

  dct_collector #(.N_FRAME(N_FRAME), .N_COEFF(N_COEFF)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .dct_data_in   (dct_data_in),
    .dct_valid_in  (dct_valid_in),
    .dct_last_in   (dct_last_in),
    .dct_ready_out (dct_ready_out),
    .mfcc_data_out (mfcc_data_out),
    .mfcc_valid_out(mfcc_valid_out),
    .mfcc_ready_in (mfcc_ready_in),
    .frame_err_out (frame_err_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    int n_beats;
    int base;
    int hold;
    bit exp_valid;
    int err_at;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_beat(input logic [15:0] d, input logic l);
    int n = 0;
    dct_data_in  = d;
    dct_valid_in = 1'b1;
    dct_last_in  = l;
    while (dct_ready_out !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("dct_ready_wait", dct_ready_out, 1);
    tick();
    dct_valid_in = 1'b0;
    dct_last_in  = 1'b0;
  endtask

  task automatic check_vector(input string name, input int base);
    for (int i = 0; i < N_COEFF; i++) begin
      check(name, mfcc_data_out[i], 16'(base + i + SKIP));
    end
  endtask

  task automatic check_all_zero();
    check("rst_valid", mfcc_valid_out, 0);
    check("rst_err", frame_err_out, 0);
    check("rst_ready", dct_ready_out, 0);
    for (int i = 0; i < N_COEFF; i++) begin
      check("rst_data", mfcc_data_out[i], 0);
    end
  endtask

  task automatic do_reset();
    dct_valid_in = 1'b0;
    dct_last_in  = 1'b0;
    rst_in = 1'b0;
    #1;
    check_all_zero();
    tick();
    tick();
    check_all_zero();
    rst_in = 1'b1;
    tick();
    check("ready_after_rst", dct_ready_out, 1);
    check("valid_after_rst", mfcc_valid_out, 0);
  endtask

  task automatic run_frame(input vec_t v);
    mfcc_ready_in = (v.hold == 0);
    for (int k = 0; k < v.n_beats; k++) begin
      send_beat(16'(v.base + k), k == v.n_beats - 1);
      check("err_pulse", frame_err_out, 16'(k == v.err_at));
      if (k != v.n_beats - 1) check("valid_early", mfcc_valid_out, 0);
    end
    check("valid_at_end", mfcc_valid_out, 16'(v.exp_valid));
    if (v.err_at >= 0) begin
      tick();
      check("err_one_cycle", frame_err_out, 0);
      check("no_valid_after_err", mfcc_valid_out, 0);
    end
    if (v.exp_valid) begin
      check_vector("data", v.base);
      for (int h = 0; h < v.hold; h++) begin
        tick();
        check("hold_valid", mfcc_valid_out, 1);
        check("hold_ready", dct_ready_out, 0);
        check_vector("hold_data", v.base);
      end
      mfcc_ready_in = 1'b1;
      tick();
      check("valid_after_hs", mfcc_valid_out, 0);
      check("ready_after_hs", dct_ready_out, 1);
    end
    mfcc_ready_in = 1'b0;
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{n_beats: 128,          base: 0,    hold: 0,  exp_valid: 1'b1, err_at: -1};
    vecs[1]  = '{n_beats: 128,          base: 0,    hold: 20, exp_valid: 1'b1, err_at: -1};
    vecs[2]  = '{n_beats: 128,          base: 100,  hold: 0,  exp_valid: 1'b1, err_at: -1};
    vecs[3]  = '{n_beats: 6,            base: 0,    hold: 0,  exp_valid: 1'b0, err_at: 5};
    vecs[4]  = '{n_beats: 128,          base: -50,  hold: 3,  exp_valid: 1'b1, err_at: -1};
    vecs[5]  = '{n_beats: 140,          base: 0,    hold: 0,  exp_valid: 1'b0, err_at: 127};
    vecs[6]  = '{n_beats: 128,          base: 7,    hold: 0,  exp_valid: 1'b1, err_at: -1};
    vecs[7]  = '{n_beats: MIN_LAST + 1, base: 200,  hold: 0,  exp_valid: 1'b1, err_at: -1};
    vecs[8]  = '{n_beats: MIN_LAST,     base: 0,    hold: 0,  exp_valid: 1'b0, err_at: MIN_LAST - 1};
    vecs[9]  = '{n_beats: MIN_LAST + 1, base: 300,  hold: 2,  exp_valid: 1'b1, err_at: -1};
    vecs[10] = '{n_beats: 129,          base: 0,    hold: 0,  exp_valid: 1'b0, err_at: 127};
    vecs[11] = '{n_beats: 128,          base: 1000, hold: 0,  exp_valid: 1'b1, err_at: -1};

    dct_data_in   = '0;
    dct_valid_in  = 1'b0;
    dct_last_in   = 1'b0;
    mfcc_ready_in = 1'b0;
    rst_in        = 1'b0;
    tick();
    do_reset();

    for (int i = 0; i < 12; i++) begin
      run_frame(vecs[i]);
    end

    // Reset part-way through a frame, then a fresh frame must start at k=0.
    for (int k = 0; k < 60; k++) send_beat(16'(700 + k), 1'b0);
    do_reset();
    v = '{n_beats: 128, base: 600, hold: 0, exp_valid: 1'b1, err_at: -1};
    run_frame(v);

    // Reset while a vector is held.
    mfcc_ready_in = 1'b0;
    for (int k = 0; k < 128; k++) send_beat(16'(800 + k), k == 127);
    check("held_valid", mfcc_valid_out, 1);
    do_reset();
    v = '{n_beats: 128, base: 900, hold: 1, exp_valid: 1'b1, err_at: -1};
    run_frame(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dct_collector.md
DCT_COLLECTOR -- requirements
Module: dct_collector

Interface
REQ-001: Parameter N_FRAME, default 128: beats per DCT output frame, tlast on the final beat.
REQ-002: Parameter N_COEFF, default 13: coefficients kept per frame, N_COEFF < N_FRAME.
REQ-003: clk_in  input  1  sole clock; all logic on its rising edge.
REQ-004: rst_in  input  1  asynchronous, active-low reset.
REQ-005: dct_data_in  input  16  signed coefficient beat from the dct stream.
REQ-006: dct_valid_in  input  1  beat valid.
REQ-007: dct_last_in  input  1  final beat of the frame.
REQ-008: dct_ready_out  output  1  block accepts a beat this cycle.
REQ-009: mfcc_data_out  output  16 x N_COEFF  unpacked array of collected coefficients, element 0 first.
REQ-010: mfcc_valid_out  output  1  mfcc_data_out holds a complete frame.
REQ-011: mfcc_ready_in  input  1  downstream accepts the vector.
REQ-012: frame_err_out  output  1  one-cycle pulse on a malformed frame.

Function
REQ-013: A beat is accepted on a cycle with dct_valid_in=1 and dct_ready_out=1; the beat index k counts from 0 per frame.
REQ-014: States: COLLECT, DRAIN, HOLD; dct_ready_out=1 in COLLECT and DRAIN, 0 in HOLD, registered from state only, with no combinational path from inputs.
REQ-015: COLLECT: accepted beat k < N_COEFF is written to mfcc_data_out[k]; beats k >= N_COEFF are discarded.
REQ-016: COLLECT, accepted beat with last=1 and k >= N_COEFF-1: go to HOLD; mfcc_valid_out=1 on the next cycle (latency 1 cycle from the last beat).
REQ-017: COLLECT, accepted beat with last=1 and k < N_COEFF-1 (short frame): frame_err_out pulses next cycle, the frame is dropped, stay in COLLECT with k reset to 0.
REQ-018: COLLECT, accepted beat k = N_FRAME-1 with last=0 (overlong frame): frame_err_out pulses next cycle, go to DRAIN.
REQ-019: DRAIN: accept and discard beats; on accepted last=1 return to COLLECT with k=0 and no vector output.
REQ-020: HOLD: mfcc_valid_out=1 and mfcc_data_out stable until mfcc_valid_out and mfcc_ready_in are both 1 in the same cycle; on that handshake go to COLLECT, so dct_ready_out=1 on the following cycle.
REQ-021: mfcc_valid_out stays 1 once asserted until the handshake, independent of mfcc_ready_in.
REQ-022: Beat counter width is $clog2(N_FRAME+1); it never wraps within a frame.
REQ-023: A beat with last=1 exactly at k = N_FRAME-1 is a normal frame end, not an error.
REQ-024: Data is passed through unmodified, with no scaling or sign change.

Reset
REQ-025: While rst_in=0: state=COLLECT, k=0, mfcc_valid_out=0, frame_err_out=0, all mfcc_data_out elements=0; dct_ready_out=1 from the first clock edge after rst_in rises.
REQ-026: Reset mid-frame or in HOLD discards any partial or held frame; beats after release start a new frame at k=0.

Configuration
REQ-027: Macro DCT_COLLECT_SKIP_C0_EN defined: beat 0 (DC term) is discarded, beats 1..N_COEFF fill elements 0..N_COEFF-1, and the short-frame threshold in REQ-016/017 becomes k >= N_COEFF.
REQ-028: Macro DCT_COLLECT_SKIP_C0_EN undefined: behaviour is exactly per REQ-015 to REQ-017.

Verification
REQ-029: A 128-beat frame with data=k, last on beat 127, mfcc_ready_in=1 -> mfcc_valid_out=1 one cycle after beat 127, elements 0..12 = 0..12, a one-cycle handshake, then dct_ready_out=1.
REQ-030: The same frame with mfcc_ready_in=0 for 20 cycles -> dct_ready_out=0 and data stable throughout, handshake on ready, then a second frame is collected correctly.
REQ-031: Last asserted on beat 5 -> frame_err_out pulse, no mfcc_valid_out; the next good frame is collected normally.
REQ-032: 140 beats with last only on beat 139 -> frame_err_out pulse after beat 127, beats 128..139 drained, no output, and the next frame is collected correctly.
REQ-033: rst_in driven low at beat 60 of a frame -> all outputs zero; a fresh frame after release outputs its own beats 0..12.
REQ-034: DCT_COLLECT_SKIP_C0_EN defined, data=k -> elements 0..12 = 1..13; a frame with last on beat 12 gives frame_err_out, and last on beat 13 is accepted.
